// File: rtl/bcd_to_bin.sv
// -----------------------------------------------------------------------------
// bcd_to_bin
//
// Sequential packed-BCD to unsigned-binary converter using reverse
// double-dabble: the digits are loaded above a BW-bit binary field, then on
// each of BW clocks the whole register shifts right by one and every BCD
// digit that reads >= 8 has 3 subtracted. After BW shifts the binary field
// holds the result. One bit is resolved per clock, so latency is BW clocks
// from the capture edge.
//
// Optional build macro:
//   BCD_CHECK_EN  - when defined, a request carrying any digit > 9 completes
//                   immediately on the capture edge with bin_out=0, err=1
//                   and no SHIFT phase. When undefined, err is tied to 0 and
//                   invalid digits are converted like any other input.
//
// Ports:
//   clk     in   rising-edge system clock
//   clear   in   asynchronous active-high reset
//   start   in   conversion request, honoured only while busy=0
//   bcd_in  in   4*NDIG packed digits, [3:0]=ones, [7:4]=tens, ...
//   bin_out out  BW-bit result, held until the next completion
//   busy    out  high while a conversion is in progress
//   done    out  one-cycle pulse in the cycle bin_out takes a new value
//   err     out  invalid-digit flag for the last conversion
// -----------------------------------------------------------------------------
module bcd_to_bin #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [BW-1:0]     bin_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SW = 4*NDIG + BW;
  // Sized to hold BW itself so the final increment does not wrap.
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sr_q,    sr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [BW-1:0] bin_q,   bin_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic [SW-1:0] sr_step;

  // One reverse double-dabble iteration: shift right, then pull every digit
  // that crossed into 8..15 back by 3 (the inverse of the forward add-3).
  always_comb begin
    sr_step = sr_q >> 1;
    for (int i = 0; i < NDIG; i++) begin
      if (sr_step[BW + 4*i +: 4] >= 4'd8) begin
        sr_step[BW + 4*i +: 4] = sr_step[BW + 4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q, err_d;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef BCD_CHECK_EN
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef BCD_CHECK_EN
          if (bad_digit) begin
            // Reject on the capture edge; busy never rises.
            bin_d  = '0;
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            err_d   = 1'b0;
`else
          begin
`endif
            sr_d    = {bcd_in, {BW{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bin_d   = sr_step[BW-1:0];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef BCD_CHECK_EN
  always_ff @(posedge clk or posedge clear) begin
    if (clear) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bin_out = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_bin
//
// Self-checking bench for bcd_to_bin (NDIG=3, BW=10). Stimulus pushes the
// expected result of each accepted request into a scoreboard queue; an
// independent monitor pops and compares whenever done is seen. Expected
// values come from decimal arithmetic on the BCD digits.
// -----------------------------------------------------------------------------
module tb_bcd_to_bin;

  localparam int NDIG = 3;
  localparam int BW   = 10;

  logic              clk    = 1'b0;
  logic              clear  = 1'b1;
  logic              start  = 1'b0;
  logic [4*NDIG-1:0] bcd_in = '0;
  logic [BW-1:0]     bin_out;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    int unsigned bin;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_to_bin #(.NDIG(NDIG), .BW(BW)) dut (
    .clk    (clk),
    .clear  (clear),
    .start  (start),
    .bcd_in (bcd_in),
    .bin_out(bin_out),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: weigh each digit by its power of ten.
  function automatic exp_t model(input logic [4*NDIG-1:0] bcd);
    exp_t e;
    int   v;
    v     = 0;
    e.err = 1'b0;
    for (int d = NDIG - 1; d >= 0; d--) begin
      int dig;
      dig = int'((bcd >> (4*d)) & 12'hF);
      if (dig > 9) e.err = 1'b1;
      v = v * 10 + dig;
    end
`ifdef BCD_CHECK_EN
    if (e.err) v = 0;
`else
    e.err = 1'b0;
`endif
    e.bin = v;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!clear && done) begin
      check("done_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("bin_out", bin_out, e.bin);
        check("err", err, e.err);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after E0.
  task automatic launch(input logic [4*NDIG-1:0] bcd);
    bcd_in = bcd;
    start  = 1'b1;
    sb.push_back(model(bcd));
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Walks the BW cycles after E0 checking busy/done timing. Optionally
  // pulses a stray start (with new digits) or aborts with clear.
  task automatic wait_done(input int inject_at, input int clear_at);
    for (int i = 0; i < BW; i++) begin
      if (i > 0) @(negedge clk);
      if (i == clear_at) begin
        clear = 1'b1;
        #1;
        check("clear_busy", busy, 0);
        check("clear_done", done, 0);
        check("clear_bin_out", bin_out, 0);
        check("clear_err", err, 0);
        @(negedge clk);
        clear = 1'b0;
        sb.delete();
        repeat (BW + 2) begin
          @(negedge clk);
          check("no_done_after_clear", done, 0);
          check("idle_after_clear", busy, 0);
        end
        return;
      end
      check("busy_during", busy, 1);
      check("done_early", done, 0);
      if (i == inject_at) begin
        start  = 1'b1;
        bcd_in = 12'h777;
      end else if (i == inject_at + 1) begin
        start  = 1'b0;
      end
    end
    @(negedge clk);
    check("done_latency", done, 1);
    check("busy_at_done", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4*NDIG-1:0] r;

    repeat (2) @(negedge clk);
    check("rst_bin_out", bin_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    clear = 1'b0;
    @(negedge clk);

    launch(12'h000); wait_done(-1, -1);
    @(negedge clk);
    check("bin_out_hold", bin_out, 0);
    check("done_one_cycle", done, 0);
    launch(12'h999); wait_done(-1, -1);
    @(negedge clk);
    launch(12'h472); wait_done(-1, -1);
    @(negedge clk);
    launch(12'h100); wait_done(-1, -1);
    @(negedge clk);

    // Stray start with new digits mid-conversion must be ignored.
    launch(12'h250); wait_done(2, -1);
    // Back-to-back: request in the done cycle.
    launch(12'h031); wait_done(-1, -1);
    @(negedge clk);

    // Abort mid-conversion, then a normal conversion.
    launch(12'h568); wait_done(-1, 4);
    launch(12'h123); wait_done(-1, -1);
    @(negedge clk);

`ifdef BCD_CHECK_EN
    launch(12'h1A5);
    check("reject_done", done, 1);
    check("reject_busy", busy, 0);
    @(negedge clk);
    check("reject_pulse_end", done, 0);
    check("reject_busy_after", busy, 0);
    launch(12'h045); wait_done(-1, -1);
    @(negedge clk);
`endif

    repeat (30) begin
      for (int d = 0; d < NDIG; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      launch(r);
      wait_done(-1, -1);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
